// File: rtl/sv32_iptw_pkg.sv
// Shared definitions for the SV32 instruction-side translation responder.
// Holds PTE bit positions, SV32 field widths, FSM state encodings, the ITLB
// entry layout and small PTE decode helpers used by sv32_iptw and sv32_itlb.
package sv32_iptw_pkg;

    // SV32 field widths
    localparam int VPN_W  = 10;
    localparam int OFF_W  = 12;
    localparam int ASID_W = 9;
    localparam int PPN_W  = 20;

    // PTE bit positions
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // PPN field of a PTE; only the low 20 bits survive the 32-bit physical address
    localparam int PTE_PPN_MSB = 31;
    localparam int PTE_PPN_LSB = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK1 = 3'd1,
        ST_WALK0 = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    typedef struct packed {
        logic [ASID_W-1:0] asid;
        logic [VPN_W-1:0]  vpn1;
        logic [VPN_W-1:0]  vpn0;
        logic              isGlobal;
        logic              isSuper;
        logic              isUser;
        logic [PPN_W-1:0]  ppn;
    } itlb_entry_t;

    // V=0, or the reserved W-without-R encoding
    function automatic logic isPteInvalid(input logic [31:0] pte);
        return !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
    endfunction

    // R or X set marks a leaf; R=X=0 points at the next level
    function automatic logic isPteLeaf(input logic [31:0] pte);
        return pte[PTE_R] || pte[PTE_X];
    endfunction

    // Fetch permission: needs X, needs A (no hardware A update), and the
    // U bit must match the current privilege exactly (SUM never helps fetch)
    function automatic logic isFetchPermFault(input logic [31:0] pte, input logic privU);
        return !pte[PTE_X] || !pte[PTE_A] || (pte[PTE_U] != privU);
    endfunction

endpackage

// File: rtl/sv32_itlb.sv
// Fully-associative instruction TLB for sv32_iptw, only instantiated when
// SV32_ITLB_EN is defined. Combinational CAM lookup, round-robin refill,
// flush invalidates every entry.
module sv32_itlb
    import sv32_iptw_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ASID_W-1:0] lookupAsid_i,
    input  logic [VPN_W-1:0]  lookupVpn1_i,
    input  logic [VPN_W-1:0]  lookupVpn0_i,
    input  logic              lookupPrivU_i,
    output logic              hit_o,
    output logic [PPN_W-1:0]  hitPpn_o,
    output logic              hitSuper_o,
    input  logic              refill_i,
    input  itlb_entry_t       refillEntry_i
);

    localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q;
    itlb_entry_t        entry_q [ENTRIES];
    logic [IdxW-1:0]    victim_q;

    // Match against every valid entry; the U bit is part of the match so a
    // privilege change falls back to a walk instead of skipping the check
    always_comb begin
        hit_o      = 1'b0;
        hitPpn_o   = '0;
        hitSuper_o = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i]
                && (entry_q[i].isGlobal || (entry_q[i].asid == lookupAsid_i))
                && (entry_q[i].vpn1 == lookupVpn1_i)
                && (entry_q[i].isSuper || (entry_q[i].vpn0 == lookupVpn0_i))
                && (entry_q[i].isUser == lookupPrivU_i)) begin
                hit_o      = 1'b1;
                hitPpn_o   = entry_q[i].ppn;
                hitSuper_o = entry_q[i].isSuper;
            end
        end
    end

    // Valid bits and victim pointer; flush wins over a same-cycle refill
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (refill_i) begin
            valid_q[victim_q] <= 1'b1;
            entry_q[victim_q] <= refillEntry_i;
            victim_q          <= victim_q + IdxW'(1);
        end
    end

endmodule

// File: rtl/sv32_iptw.sv
// SV32 instruction-side translation responder. Takes the fetch unit's
// translation request, walks the two-level page table through a single
// outstanding PTE read port and returns paddr / page-fault as a one-cycle
// response pulse. Define SV32_ITLB_EN to add a TLB_ENTRIES-entry ITLB that
// answers hits from IDLE without touching memory.
module sv32_iptw
    import sv32_iptw_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_vaddr_i,
    input  logic        req_valid_i,
    output logic [31:0] resp_paddr_o,
    output logic        resp_valid_o,
    output logic        resp_fault_o,
    input  logic        mmu_enable_i,
    input  logic [21:0] satp_ppn_i,
    input  logic [8:0]  satp_asid_i,
    input  logic        priv_u_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    input  logic        flush_i
);

    state_e             state_q, state_d;
    logic [31:0]        vaddr_q, vaddr_d;
    logic [PPN_W-1:0]   tablePpn_q, tablePpn_d;
    logic [ASID_W-1:0]  asid_q, asid_d;
    logic               privU_q, privU_d;
    logic [31:0]        paddr_q, paddr_d;
    logic               fault_q, fault_d;

    logic [VPN_W-1:0]   vpn1, vpn0, walkVpn;
    logic [OFF_W-1:0]   pageOff;
    logic               pteInvalid, pteLeaf, pteMisaligned, permFault;
    logic               refillValid;
    itlb_entry_t        refillEntry;

    logic               tlbHit;
    logic [PPN_W-1:0]   tlbPpn;
    logic               tlbSuper;
    logic [31:0]        tlbPaddr;

    assign vpn1    = vaddr_q[31:22];
    assign vpn0    = vaddr_q[21:12];
    assign pageOff = vaddr_q[OFF_W-1:0];
    assign walkVpn = (state_q == ST_WALK0) ? vpn0 : vpn1;

    assign pteInvalid    = isPteInvalid(mem_rdata_i);
    assign pteLeaf       = isPteLeaf(mem_rdata_i);
    assign pteMisaligned = |mem_rdata_i[PTE_PPN_LSB +: VPN_W];
    assign permFault     = isFetchPermFault(mem_rdata_i, privU_q);

    // tablePpn_q holds satp.PPN during WALK1 and the next-level base in WALK0
    assign mem_req_o    = (state_q == ST_WALK1) || (state_q == ST_WALK0);
    assign mem_addr_o   = {tablePpn_q, walkVpn, 2'b00};
    assign resp_valid_o = (state_q == ST_DONE) && !flush_i;
    assign resp_paddr_o = paddr_q;
    assign resp_fault_o = fault_q;

    assign tlbPaddr = tlbSuper ? {tlbPpn[PPN_W-1:VPN_W], req_vaddr_i[21:0]}
                               : {tlbPpn, req_vaddr_i[OFF_W-1:0]};

`ifdef SV32_ITLB_EN
    sv32_itlb #(
        .ENTRIES       (TLB_ENTRIES)
    ) u_itlb (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .lookupAsid_i  (satp_asid_i),
        .lookupVpn1_i  (req_vaddr_i[31:22]),
        .lookupVpn0_i  (req_vaddr_i[21:12]),
        .lookupPrivU_i (priv_u_i),
        .hit_o         (tlbHit),
        .hitPpn_o      (tlbPpn),
        .hitSuper_o    (tlbSuper),
        .refill_i      (refillValid),
        .refillEntry_i (refillEntry)
    );
`else
    logic unusedTlb;
    assign tlbHit    = 1'b0;
    assign tlbPpn    = '0;
    assign tlbSuper  = 1'b0;
    assign unusedTlb = ^{refillValid, refillEntry, 5'(TLB_ENTRIES)};
`endif

    // PTE bits that never reach the 32-bit physical address or are not checked
    logic unusedBits;
    assign unusedBits = ^{mem_rdata_i[PTE_PPN_MSB -: 2], mem_rdata_i[PTE_D], satp_ppn_i[21:20]};

    // Next-state logic: request capture, two-level walk, response and flush/drain
    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        tablePpn_d  = tablePpn_q;
        asid_d      = asid_q;
        privU_d     = privU_q;
        paddr_d     = paddr_q;
        fault_d     = fault_q;
        refillValid = 1'b0;
        refillEntry = '{asid:     asid_q,
                        vpn1:     vpn1,
                        vpn0:     vpn0,
                        isGlobal: mem_rdata_i[PTE_G],
                        isSuper:  (state_q == ST_WALK1),
                        isUser:   mem_rdata_i[PTE_U],
                        ppn:      mem_rdata_i[PTE_PPN_LSB +: PPN_W]};

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    vaddr_d    = req_vaddr_i;
                    tablePpn_d = satp_ppn_i[PPN_W-1:0];
                    asid_d     = satp_asid_i;
                    privU_d    = priv_u_i;
                    fault_d    = 1'b0;
                    if (!mmu_enable_i) begin
                        paddr_d = req_vaddr_i;
                        state_d = ST_DONE;
                    end else if (tlbHit) begin
                        paddr_d = tlbPaddr;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WALK1;
                    end
                end
            end

            ST_WALK1: begin
                if (flush_i) begin
                    state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid_i) begin
                    state_d = ST_DONE;
                    paddr_d = '0;
                    fault_d = 1'b1;
                    if (!pteInvalid && !pteLeaf) begin
                        tablePpn_d = mem_rdata_i[PTE_PPN_LSB +: PPN_W];
                        fault_d    = 1'b0;
                        state_d    = ST_WALK0;
                    end else if (!pteInvalid && !pteMisaligned && !permFault) begin
                        paddr_d     = {mem_rdata_i[29:20], vpn0, pageOff};
                        fault_d     = 1'b0;
                        refillValid = 1'b1;
                        refillEntry.ppn = {mem_rdata_i[29:20], {VPN_W{1'b0}}};
                    end
                end
            end

            ST_WALK0: begin
                if (flush_i) begin
                    state_d = mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid_i) begin
                    state_d = ST_DONE;
                    paddr_d = '0;
                    fault_d = 1'b1;
                    if (!pteInvalid && pteLeaf && !permFault) begin
                        paddr_d     = {mem_rdata_i[PTE_PPN_LSB +: PPN_W], pageOff};
                        fault_d     = 1'b0;
                        refillValid = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vaddr_q    <= '0;
            tablePpn_q <= '0;
            asid_q     <= '0;
            privU_q    <= 1'b0;
            paddr_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            tablePpn_q <= tablePpn_d;
            asid_q     <= asid_d;
            privU_q    <= privU_d;
            paddr_q    <= paddr_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_sv32_iptw.sv
// Self-checking bench for sv32_iptw. A small PTE memory answers walk reads,
// expected responses go into a scoreboard queue when a request is driven and
// are compared when resp_valid_o pulses. Build with SV32_ITLB_EN to add the
// ITLB hit/flush checks.
`timescale 1ns/1ps
module tb_sv32_iptw;

    logic        clk;
    logic        rst;
    logic [31:0] req_vaddr_i;
    logic        req_valid_i;
    logic [31:0] resp_paddr_o;
    logic        resp_valid_o;
    logic        resp_fault_o;
    logic        mmu_enable_i;
    logic [21:0] satp_ppn_i;
    logic [8:0]  satp_asid_i;
    logic        priv_u_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;
    logic        flush_i;

    sv32_iptw #(.TLB_ENTRIES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vaddr_i  (req_vaddr_i),
        .req_valid_i  (req_valid_i),
        .resp_paddr_o (resp_paddr_o),
        .resp_valid_o (resp_valid_o),
        .resp_fault_o (resp_fault_o),
        .mmu_enable_i (mmu_enable_i),
        .satp_ppn_i   (satp_ppn_i),
        .satp_asid_i  (satp_asid_i),
        .priv_u_i     (priv_u_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .flush_i      (flush_i)
    );

    typedef struct packed {
        logic [31:0] paddr;
        logic        fault;
    } exp_t;

    exp_t        expQ[$];
    string       tagQ[$];
    logic [31:0] readLog[$];
    logic [31:0] memA[4];
    logic [31:0] memD[4];
    logic        memStall;
    logic [31:0] memStallAddr;
    logic        memIssued;
    int          vectorCount;
    int          miscompares;
    int          respCount;
    int          lastRespCycle;
    int          reqCycle;
    int          memReqCycles;
    int          cycle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurements
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memLookup(input logic [31:0] addr);
        logic [31:0] data;
        data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (memA[i] == addr) data = memD[i];
        end
        return data;
    endfunction

    // PTE memory: answers a held request one cycle after it is seen,
    // unless the address is being deliberately stalled
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        memIssued    = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req_o) memReqCycles++;
            if (memIssued) begin
                mem_rvalid_i = 1'b0;
                memIssued    = 1'b0;
            end else if (mem_req_o && !(memStall && (mem_addr_o == memStallAddr))) begin
                mem_rdata_i  = memLookup(mem_addr_o);
                mem_rvalid_i = 1'b1;
                memIssued    = 1'b1;
                readLog.push_back(mem_addr_o);
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid_o) begin
                respCount++;
                lastRespCycle = cycle;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedResp", 32'(resp_valid_o), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    t = tagQ.pop_front();
                    checkOutput($sformatf("%s.fault", t), 32'(resp_fault_o), 32'(e.fault));
                    if (!e.fault) checkOutput($sformatf("%s.paddr", t), resp_paddr_o, e.paddr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic issueRequest(input logic [31:0] vaddr, input logic enable, input logic privU);
        @(negedge clk);
        req_vaddr_i  = vaddr;
        mmu_enable_i = enable;
        priv_u_i     = privU;
        req_valid_i  = 1'b1;
        reqCycle     = cycle;
        @(negedge clk);
        req_valid_i  = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] vaddr, input logic enable,
                                 input logic privU, input logic [31:0] expPaddr, input logic expFault);
        int n;
        n = respCount;
        expQ.push_back('{paddr: expPaddr, fault: expFault});
        tagQ.push_back(tag);
        issueRequest(vaddr, enable, privU);
        for (int i = 0; i < 40 && respCount == n; i++) begin
            @(negedge clk);
            #2;
        end
        checkOutput($sformatf("%s.resp", tag), 32'(respCount), 32'(n + 1));
        if (respCount == n) begin
            expQ.delete();
            tagQ.delete();
        end
        @(negedge clk);
        #2;
    endtask

    task automatic flushTlb();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic runWalk(input string tag, input logic [31:0] rootPte, input logic [31:0] leafPte,
                           input logic privU, input logic [31:0] expPaddr, input logic expFault,
                           input int expReads);
        flushTlb();
        memA[0] = 32'h0008_0400; memD[0] = rootPte;
        memA[1] = 32'h0008_1004; memD[1] = leafPte;
        readLog.delete();
        applyStimulus(tag, 32'h4000_1234, 1'b1, privU, expPaddr, expFault);
        checkOutput($sformatf("%s.reads", tag), 32'(readLog.size()), 32'(expReads));
        if (readLog.size() > 0) checkOutput($sformatf("%s.addr1", tag), readLog[0], 32'h0008_0400);
        if (readLog.size() > 1) checkOutput($sformatf("%s.addr0", tag), readLog[1], 32'h0008_1004);
    endtask

    initial begin
        int  n;
        logic found;
        vectorCount  = 0;
        miscompares  = 0;
        respCount    = 0;
        memReqCycles = 0;
        cycle        = 0;
        memStall     = 1'b0;
        memStallAddr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            memA[i] = 32'hFFFF_FFFF;
            memD[i] = 32'h0;
        end
        rst          = 1'b1;
        req_vaddr_i  = 32'h0;
        req_valid_i  = 1'b0;
        mmu_enable_i = 1'b1;
        satp_ppn_i   = 22'h80;
        satp_asid_i  = 9'h5;
        priv_u_i     = 1'b0;
        flush_i      = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.respValid", 32'(resp_valid_o), 32'd0);
        checkOutput("reset.respFault", 32'(resp_fault_o), 32'd0);
        checkOutput("reset.respPaddr", resp_paddr_o, 32'd0);
        checkOutput("reset.memReq", 32'(mem_req_o), 32'd0);
        checkOutput("reset.memAddr", mem_addr_o, 32'd0);
        rst = 1'b0;

        // Bypass: one-cycle latency, no memory traffic
        memReqCycles = 0;
        applyStimulus("bypass", 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
        checkOutput("bypass.latency", 32'(lastRespCycle - reqCycle), 32'd1);
        checkOutput("bypass.memReq", 32'(memReqCycles), 32'd0);

        // Two-level walks and single-level megapages
        runWalk("walk4k",      32'h0002_0401, 32'h048D_1449, 1'b0, 32'h1234_5234, 1'b0, 2);
        runWalk("mega",        32'h0020_0049, 32'h0,         1'b0, 32'h0080_1234, 1'b0, 1);
        runWalk("megaMisalgn", 32'h0020_0449, 32'h0,         1'b0, 32'h0,         1'b1, 1);
        runWalk("userPageSup", 32'h0002_0401, 32'h048D_1459, 1'b0, 32'h0,         1'b1, 2);
        runWalk("noExec",      32'h0002_0401, 32'h048D_1441, 1'b0, 32'h0,         1'b1, 2);
        runWalk("userPageUsr", 32'h0002_0401, 32'h048D_1459, 1'b1, 32'h1234_5234, 1'b0, 2);
        runWalk("supPageUsr",  32'h0002_0401, 32'h048D_1449, 1'b1, 32'h0,         1'b1, 2);
        runWalk("noAccessed",  32'h0002_0401, 32'h048D_1409, 1'b0, 32'h0,         1'b1, 2);
        runWalk("writeNoRead", 32'h0002_0401, 32'h048D_144D, 1'b0, 32'h0,         1'b1, 2);
        runWalk("rootInvalid", 32'h0000_0000, 32'h048D_1449, 1'b0, 32'h0,         1'b1, 1);

        // Flush while the level-0 read is outstanding, data returns three cycles later
        flushTlb();
        memA[0] = 32'h0008_0400; memD[0] = 32'h0002_0401;
        memA[1] = 32'h0008_1004; memD[1] = 32'h048D_1449;
        memStallAddr = 32'h0008_1004;
        memStall     = 1'b1;
        readLog.delete();
        n = respCount;
        issueRequest(32'h4000_1234, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (mem_req_o && (mem_addr_o == 32'h0008_1004)) found = 1'b1;
        end
        checkOutput("flush.reachWalk0", 32'(found), 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        checkOutput("flush.drainReq0", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("flush.drainReq1", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        mem_rdata_i  = 32'h048D_1449;
        mem_rvalid_i = 1'b1;
        #1;
        checkOutput("flush.drainReq2", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        memStall     = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("flush.noResp", 32'(respCount), 32'(n));
        checkOutput("flush.reads", 32'(readLog.size()), 32'd1);
        runWalk("postFlush", 32'h0002_0401, 32'h048D_1449, 1'b0, 32'h1234_5234, 1'b0, 2);

        // Reset in the middle of a stalled level-1 read
        memStallAddr = 32'h0008_0400;
        memStall     = 1'b1;
        issueRequest(32'h4000_1234, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (mem_req_o) found = 1'b1;
        end
        checkOutput("rstMid.reqSeen", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rstMid.memReq", 32'(mem_req_o), 32'd0);
        checkOutput("rstMid.respValid", 32'(resp_valid_o), 32'd0);
        rst      = 1'b0;
        memStall = 1'b0;
        runWalk("postReset", 32'h0002_0401, 32'h048D_1449, 1'b0, 32'h1234_5234, 1'b0, 2);

`ifdef SV32_ITLB_EN
        // ITLB: refill from a walk, hit without memory, flush forces a new walk
        runWalk("tlbFill", 32'h0002_0401, 32'h048D_1449, 1'b0, 32'h1234_5234, 1'b0, 2);
        readLog.delete();
        memReqCycles = 0;
        applyStimulus("tlbHit", 32'h4000_1234, 1'b1, 1'b0, 32'h1234_5234, 1'b0);
        checkOutput("tlbHit.latency", 32'(lastRespCycle - reqCycle), 32'd1);
        checkOutput("tlbHit.memReq", 32'(memReqCycles), 32'd0);
        runWalk("tlbMegaFill", 32'h0020_0049, 32'h0, 1'b0, 32'h0080_1234, 1'b0, 1);
        readLog.delete();
        applyStimulus("tlbMegaHit", 32'h4000_1ABC, 1'b1, 1'b0, 32'h0080_1ABC, 1'b0);
        checkOutput("tlbMegaHit.reads", 32'(readLog.size()), 32'd0);
        runWalk("tlbAfterFlush", 32'h0002_0401, 32'h048D_1449, 1'b0, 32'h1234_5234, 1'b0, 2);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
